// File: rtl/uart_tx.sv
// UART transmitter paced by an external one-cycle baud tick; frames are sent LSB first.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN (PARITY_ODD selects odd sense).
module uart_tx #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy
);

  localparam int   CW        = $clog2(DATA_W);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (DATA_W < 5 || DATA_W > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              stop_q, stop_d;
  logic              pending_q, pending_d;
  logic              tx_q, tx_d;
  logic              accept;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign ready  = (state_q == S_IDLE) ||
                  ((state_q == S_STOP) && (stop_q == STOP_LAST) && !pending_q);
  assign accept = valid && ready;
  assign busy   = (state_q != S_IDLE) || pending_q;
  assign tx     = tx_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    stop_d    = stop_q;
    pending_d = pending_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    // The shift register is idle whenever ready is high, so a new word can land at once.
    if (accept) begin
      shift_d   = data;
      pending_d = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d  = (^data) ^ (PARITY_ODD != 0);
`endif
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick) begin
          tx_d      = 1'b0;
          pending_d = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (cnt_q == CW'(DATA_W - 1)) begin
            stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (stop_q == STOP_LAST) begin
            if (pending_q) begin
              tx_d      = 1'b0;
              pending_d = 1'b0;
              state_d   = S_START;
            end else if (accept) begin
              // Word taken on the very tick that ends the frame: start waits for the next tick.
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d      = 1'b1;
        pending_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      stop_q    <= 1'b0;
      pending_q <= 1'b0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      stop_q    <= stop_d;
      pending_q <= pending_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: instance 0 uses one stop bit, instance 1 two; a bit-queue line model
// is compared every cycle, and hand-computed frame patterns pin the model.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int          NB_1  = 11;
  localparam logic [31:0] E_A5  = 32'h54A;
  localparam int          NB_BB = 22;
  localparam logic [31:0] E_BB  = 32'h2FF400;
  localparam int          NB_2  = 12;
  localparam logic [31:0] E_S2  = 32'hD02;
`else
  localparam int          NB_1  = 10;
  localparam logic [31:0] E_A5  = 32'h34A;
  localparam int          NB_BB = 20;
  localparam logic [31:0] E_BB  = 32'hFFA00;
  localparam int          NB_2  = 11;
  localparam logic [31:0] E_S2  = 32'h702;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          tick_fast = 1'b0;
  logic [DW-1:0] data_a [2];
  logic [1:0]    valid_v = 2'b00;
  logic [1:0]    ready_v, tx_v, busy_v;
  int            n_tests = 0;
  int            n_fail = 0;
  int            tphase = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    uart_tx #(.DATA_W(DW), .STOP_BITS(gi + 1), .PARITY_ODD(0)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .data (data_a[gi]),
      .valid(valid_v[gi]),
      .ready(ready_v[gi]),
      .tx   (tx_v[gi]),
      .busy (busy_v[gi])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick source: every 4th clk, or every clk when tick_fast is set.
  initial forever begin
    @(negedge clk);
    if (tick_fast) tick = 1'b1;
    else begin
      tphase = (tphase + 1) % 4;
      tick   = (tphase == 0);
    end
  end

  // Line model: an accepted word becomes a queue of line levels; each tick moves the next level onto the line.
  logic m_line [2];
  logic m_act  [2];
  logic m_q    [2][32];
  int   m_cnt  [2];

  task automatic push(input int i, input logic v);
    m_q[i][m_cnt[i]] = v;
    m_cnt[i]++;
  endtask

  initial begin
    bit acc;
    for (int i = 0; i < 2; i++) begin
      m_line[i] = 1'b1; m_act[i] = 1'b0; m_cnt[i] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_line[i] = 1'b1; m_act[i] = 1'b0; m_cnt[i] = 0;
        end else begin
          acc = valid_v[i] && (m_cnt[i] == 0);
          if (tick) begin
            if (m_cnt[i] > 0) begin
              m_line[i] = m_q[i][0];
              for (int k = 0; k < 31; k++) m_q[i][k] = m_q[i][k+1];
              m_cnt[i]--;
              m_act[i] = 1'b1;
            end else begin
              m_act[i] = 1'b0;
            end
          end
          if (acc) begin
            push(i, 1'b0);
            for (int b = 0; b < DW; b++) push(i, data_a[i][b]);
`ifdef UART_TX_PARITY_EN
            push(i, ^data_a[i]);
`endif
            for (int s = 0; s <= i; s++) push(i, 1'b1);
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tx%0d", i), tx_v[i], m_line[i]);
      check($sformatf("ready%0d", i), ready_v[i], m_cnt[i] == 0);
      check($sformatf("busy%0d", i), busy_v[i], (m_cnt[i] > 0) || m_act[i]);
    end
  end

  task automatic send(input int i, input logic [7:0] w);
    bit done = 0;
    data_a[i]  = w;
    valid_v[i] = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      if (ready_v[i]) done = 1;
      @(negedge clk);
    end
    valid_v[i] = 1'b0;
    check($sformatf("send%0d_accepted", i), done, 1);
  endtask

  // Waits for the start bit, then checks each level is held for exactly 4 clk.
  task automatic check_seq(input int i, input int nb, input logic [31:0] exp, input string name);
    int n = 0;
    logic [3:0] got;
    while (tx_v[i] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_start_seen"}, n < 100, 1);
    if (n < 100) begin
      for (int k = 0; k < nb; k++) begin
        for (int s = 0; s < 4; s++) begin
          if (k > 0 || s > 0) @(negedge clk);
          got[s] = tx_v[i];
        end
        check($sformatf("%s_bit%0d", name, k), got, {4{exp[k]}});
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_v != 2'b00 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", n < 400, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n, k, zeros;
    data_a[0] = 8'hFF;
    data_a[1] = 8'h00;
    valid_v   = 2'b11;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_tx%0d", i), tx_v[i], 1);
      check($sformatf("rst_ready%0d", i), ready_v[i], 1);
      check($sformatf("rst_busy%0d", i), busy_v[i], 0);
    end
    valid_v = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy_v, 2'b00);

    fork
      send(0, 8'hA5);
      check_seq(0, NB_1, E_A5, "a5");
    join
    wait_idle();

`ifdef UART_TX_PARITY_EN
    fork
      send(0, 8'h01);
      check_seq(0, 11, 32'h602, "p01");
    join
    wait_idle();
`endif

    send(0, 8'h00);
    fork
      send(0, 8'hFF);
      check_seq(0, NB_BB, E_BB, "b2b");
    join
    wait_idle();

    // Accept on a tick cycle: the start bit must wait a full period for the next tick.
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(tick && ready_v[0]) && n < 50);
    data_a[0]  = 8'h5A;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    k = 0;
    while (tx_v[0] === 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("tick_accept_delay", k, 4);
    wait_idle();

    fork
      send(1, 8'h81);
      check_seq(1, NB_2, E_S2, "stop2");
    join
    wait_idle();

    tick_fast = 1'b1;
    send(1, 8'h96);
    send(1, 8'h69);
    send(0, 8'hC3);
    wait_idle();
    tick_fast = 1'b0;
    repeat (4) @(negedge clk);

    send(0, 8'h3C);
    n = 0;
    while (tx_v[0] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (9) @(negedge clk);
    check("mid_bit1_low", tx_v[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", tx_v[0], 1);
    check("rst_async_ready", ready_v[0], 1);
    check("rst_async_busy", busy_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    zeros = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) zeros++;
    end
    check("no_residual_bits", zeros, 0);
    check("post_abort_busy", busy_v[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
